i2c_cmd_engine: RTL and testbench
=================================

I2C_CMD_ENGINE -- requirements
Module: i2c_cmd_engine

Interface
REQ-001 Parameter DIV_W, default 8, width of the quarter-period divider value.
REQ-002 clock  input  1  block clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd  input  4  bus command code (IDLE=0, START=1, 1=2, 0=3, STOP=4, ACK=5, WR=6, RD=7, L0=8, L1=9, OSCL=10, MACK=11).
REQ-005 cmd_vld  input  1  cmd valid.
REQ-006 cmd_rdy  output  1  engine accepts cmd this cycle.
REQ-007 qdiv  input  DIV_W  quarter-period length minus one, in clock cycles.
REQ-008 scl_o  output  1  SCL drive, 1 = release, 0 = pull low.
REQ-009 sda_o  output  1  SDA drive, 1 = release, 0 = pull low.
REQ-010 scl_i  input  1  sampled SCL line.
REQ-011 sda_i  input  1  sampled SDA line.
REQ-012 rd_bit  output  1  last sampled SDA bit (ACK/RD).
REQ-013 rd_vld  output  1  one-cycle pulse, rd_bit updated.
REQ-014 busy  output  1  command executing.
REQ-015 err  output  1  one-cycle pulse, illegal command accepted.

Function
REQ-016 States: IDLE, RUN; RUN holds a 2-bit quarter index Q0..Q3 and a DIV_W-bit quarter counter.
REQ-017 cmd_rdy = 1 in IDLE only; transfer occurs when cmd_vld and cmd_rdy are both 1 on a rising edge.
REQ-018 On transfer: cmd and qdiv latched, busy=1 from next cycle, state RUN at Q0, counter 0; qdiv changes during RUN are ignored.
REQ-019 Each quarter lasts qdiv+1 cycles (qdiv=0 -> 1 cycle); a command lasts 4*(qdiv+1) cycles, then IDLE for at least one cycle (busy=0, cmd_rdy=1).
REQ-020 scl_o/sda_o per quarter Q0..Q3: START scl 1,1,1,0 sda 1,1,0,0; STOP scl 0,1,1,1 sda 0,0,1,1.
REQ-021 1/L1: sda 1 all quarters; 0/L0/MACK: sda 0 all quarters; scl 0,1,1,0 for all of these.
REQ-022 ACK/RD/OSCL: sda 1 (released), scl 0,1,1,0; ACK/RD sample sda_i on last cycle of Q2, rd_bit updated and rd_vld pulsed on the following cycle; OSCL does not sample.
REQ-023 IDLE command: accepted, no bus activity, no RUN entry, busy stays 0.
REQ-024 WR and codes 12-15: accepted, err pulses one cycle after transfer, no bus activity, outputs unchanged.
REQ-025 In IDLE, scl_o/sda_o hold the values from Q3 of the previous command (bus level preserved between commands).
REQ-026 rd_bit holds its value until the next ACK/RD sample.

Reset
REQ-027 rst_n low immediately forces: state IDLE, scl_o=1, sda_o=1, busy=0, rd_bit=0, rd_vld=0, err=0, counters 0; cmd_rdy=1 after release.
REQ-028 Reset asserted mid-command aborts the command with no completion pulse; the bus is released within the reset assertion.

Configuration
REQ-029 Macro I2C_CLK_STRETCH_EN defined: while scl_o=1 in Q1 or Q2 and scl_i=0, the quarter counter holds, extending the quarter until scl_i=1.
REQ-030 Macro I2C_CLK_STRETCH_EN undefined: scl_i is ignored, timing is strictly 4*(qdiv+1) cycles.

Verification
REQ-031 qdiv=3, START then STOP -> each 16 cycles; SDA falls at cycle 8 of START while SCL=1; SDA rises at cycle 8 of STOP while SCL=1.
REQ-032 qdiv=0, bit sequence 1,0,1 with cmd_vld held -> 4-cycle SCL pulses, cmd_rdy high one cycle between commands, sda_o 1/0/1.
REQ-033 qdiv=2, ACK with sda_i=0 -> rd_vld pulse at cycle 10 after transfer, rd_bit=0; RD with sda_i=1 -> rd_bit=1.
REQ-034 cmd=13 -> err pulse next cycle, busy stays 0, scl_o/sda_o unchanged.
REQ-035 rst_n pulled low at cycle 5 of a qdiv=3 STOP -> scl_o=sda_o=1 immediately, no rd_vld/err, cmd_rdy=1 after release.
REQ-036 I2C_CLK_STRETCH_EN defined, qdiv=1, bit 1 with scl_i held 0 for 10 cycles in Q1 -> command lengthens by 10 cycles; undefined -> stays 8 cycles.

Source files
------------

// File: rtl/i2c_cmd_engine.sv
// i2c_cmd_engine: executes one I2C bus primitive per command, each split into four equal quarters.
// Optional SCL clock stretching is compiled in when I2C_CLK_STRETCH_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a command; bus levels from the last quarter are held
// RUN     | driving quarters Q0..Q3 of the latched command
module i2c_cmd_engine #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [3:0]       cmd,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [DIV_W-1:0] qdiv,
  output logic             scl_o,
  output logic             sda_o,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             rd_bit,
  output logic             rd_vld,
  output logic             busy,
  output logic             err
);
  localparam logic [3:0] C_IDLE  = 4'd0;
  localparam logic [3:0] C_START = 4'd1;
  localparam logic [3:0] C_BIT0  = 4'd3;
  localparam logic [3:0] C_STOP  = 4'd4;
  localparam logic [3:0] C_ACK   = 4'd5;
  localparam logic [3:0] C_WR    = 4'd6;
  localparam logic [3:0] C_RD    = 4'd7;
  localparam logic [3:0] C_L0    = 4'd8;
  localparam logic [3:0] C_MACK  = 4'd11;
  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       qtr_q, qtr_d, qtr_nxt;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] qdiv_q, qdiv_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             scl_q, scl_d, sda_q, sda_d;
  logic             rd_bit_q, rd_bit_d, rd_vld_q, rd_vld_d, err_q, err_d;
  logic             samp_q, samp_d, pend_q, pend_d;
  logic             stall;

  // Returns {scl, sda} for command c during quarter q.
  function automatic logic [1:0] bus_lvl(input logic [3:0] c, input logic [1:0] q);
    logic mid;
    mid = (q == 2'd1) || (q == 2'd2);
    case (c)
      C_START:              bus_lvl = {q != 2'd3, ~q[1]};
      C_STOP:               bus_lvl = {q != 2'd0, q[1]};
      C_BIT0, C_L0, C_MACK: bus_lvl = {mid, 1'b0};
      default:              bus_lvl = {mid, 1'b1};
    endcase
  endfunction

`ifdef I2C_CLK_STRETCH_EN
  assign stall = scl_q && ((qtr_q == 2'd1) || (qtr_q == 2'd2)) && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign stall = 1'b0;
`endif

  assign qtr_nxt = qtr_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    qtr_d    = qtr_q;
    cnt_d    = cnt_q;
    qdiv_d   = qdiv_q;
    cmd_d    = cmd_q;
    scl_d    = scl_q;
    sda_d    = sda_q;
    rd_bit_d = rd_bit_q;
    rd_vld_d = 1'b0;
    err_d    = 1'b0;
    samp_d   = samp_q;
    pend_d   = 1'b0;

    // sample captured at the end of Q2 is published one cycle later
    if (pend_q) begin
      rd_bit_d = samp_q;
      rd_vld_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_vld) begin
          if ((cmd == C_WR) || (cmd >= 4'd12)) begin
            err_d = 1'b1;
          end else if (cmd != C_IDLE) begin
            state_d        = ST_RUN;
            qtr_d          = 2'd0;
            cnt_d          = '0;
            cmd_d          = cmd;
            qdiv_d         = qdiv;
            {scl_d, sda_d} = bus_lvl(cmd, 2'd0);
          end
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (cnt_q == qdiv_q) begin
            cnt_d = '0;
            if ((qtr_q == 2'd2) && ((cmd_q == C_ACK) || (cmd_q == C_RD))) begin
              samp_d = sda_i;
              pend_d = 1'b1;
            end
            if (qtr_q == 2'd3) begin
              state_d = ST_IDLE;
            end else begin
              qtr_d          = qtr_nxt;
              {scl_d, sda_d} = bus_lvl(cmd_q, qtr_nxt);
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      qtr_q    <= 2'd0;
      cnt_q    <= '0;
      qdiv_q   <= '0;
      cmd_q    <= 4'd0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      rd_bit_q <= 1'b0;
      rd_vld_q <= 1'b0;
      err_q    <= 1'b0;
      samp_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      qtr_q    <= qtr_d;
      cnt_q    <= cnt_d;
      qdiv_q   <= qdiv_d;
      cmd_q    <= cmd_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      rd_bit_q <= rd_bit_d;
      rd_vld_q <= rd_vld_d;
      err_q    <= err_d;
      samp_q   <= samp_d;
      pend_q   <= pend_d;
    end
  end

  assign cmd_rdy = (state_q == ST_IDLE);
  assign busy    = (state_q == ST_RUN);
  assign scl_o   = scl_q;
  assign sda_o   = sda_q;
  assign rd_bit  = rd_bit_q;
  assign rd_vld  = rd_vld_q;
  assign err     = err_q;
endmodule

// File: tb/tb_i2c_cmd_engine.sv
// Testbench for i2c_cmd_engine: directed vector table, hand sequences for reset/stretch,
// and random commands checked cycle by cycle against a quarter-waveform reference model.
module tb_i2c_cmd_engine;
  logic       clock = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] cmd = 4'd0;
  logic       cmd_vld = 1'b0;
  logic       cmd_rdy;
  logic [7:0] qdiv = 8'd0;
  logic       scl_o, sda_o;
  logic       scl_i = 1'b1;
  logic       sda_i = 1'b1;
  logic       rd_bit, rd_vld, busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic m_rd_bit = 1'b0;

  always #5 clock = ~clock;

  i2c_cmd_engine #(.DIV_W(8)) dut (
    .clock(clock), .rst_n(rst_n), .cmd(cmd), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .qdiv(qdiv), .scl_o(scl_o), .sda_o(sda_o), .scl_i(scl_i), .sda_i(sda_i),
    .rd_bit(rd_bit), .rd_vld(rd_vld), .busy(busy), .err(err)
  );

  typedef struct {
    logic [3:0] c;
    int         qd;
    logic       sdi;
    int         blen;
    logic       err;
    int         rdv;
    logic       rdb;
    logic       fscl;
    logic       fsda;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Waveforms written Q0..Q3 left to right, straight from the command descriptions.
  function automatic logic [1:0] pat(input logic [3:0] c, input int q);
    logic [3:0] s, d;
    case (c)
      4'd1:             begin s = 4'b1110; d = 4'b1100; end
      4'd4:             begin s = 4'b0111; d = 4'b0011; end
      4'd3, 4'd8, 4'd11: begin s = 4'b0110; d = 4'b0000; end
      default:          begin s = 4'b0110; d = 4'b1111; end
    endcase
    return {s[3-q], d[3-q]};
  endfunction

  task automatic wait_rdy();
    int n;
    n = 0;
    while (!cmd_rdy && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("rdy_wait", cmd_rdy, 1);
  endtask

  task automatic exec(input logic [3:0] c, input int qd, input logic sdi,
                      output int blen, output int rdv_e, output logic err_seen);
    logic ill, noop, exp_rdv;
    int run_len, last_e;
    logic [1:0] bl;
    logic [6:0] exp_v;
    ill     = (c == 4'd6) || (c >= 4'd12);
    noop    = ill || (c == 4'd0);
    run_len = noop ? 0 : 4 * (qd + 1);
    last_e  = noop ? 1 : run_len;
    blen = 0; rdv_e = -1; err_seen = 1'b0;
    wait_rdy();
    cmd = c; qdiv = qd[7:0]; sda_i = sdi; cmd_vld = 1'b1;
    @(posedge clock); #1;
    cmd_vld = 1'b0;
    cmd  = 4'($urandom);
    qdiv = 8'($urandom);
    for (int e = 0; e <= last_e; e++) begin
      if (e > 0) begin @(posedge clock); #1; end
      exp_rdv = ((c == 4'd5) || (c == 4'd7)) && (e == 3 * (qd + 1) + 1);
      if (exp_rdv) m_rd_bit = sdi;
      if (e < run_len)  bl = pat(c, e / (qd + 1));
      else if (!noop)   bl = pat(c, 3);
      else              bl = {m_scl, m_sda};
      m_scl = bl[1];
      m_sda = bl[0];
      exp_v = {e < run_len, !(e < run_len), bl, exp_rdv, m_rd_bit, ill && (e == 0)};
      chk("cyc", {busy, cmd_rdy, scl_o, sda_o, rd_vld, rd_bit, err}, exp_v);
      if (busy)   blen++;
      if (rd_vld) rdv_e = e;
      if (err)    err_seen = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int blen, rdv, e;
    logic errs;
    logic [3:0] rc;
    int rqd;
    logic rsd;

    tbl[0]  = '{4'd1,  3, 1'b1, 16, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'd4,  3, 1'b1, 16, 1'b0, -1, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{4'd2,  0, 1'b1,  4, 1'b0, -1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{4'd3,  0, 1'b1,  4, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'd2,  0, 1'b1,  4, 1'b0, -1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{4'd5,  2, 1'b0, 12, 1'b0, 10, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{4'd7,  2, 1'b1, 12, 1'b0, 10, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{4'd13, 1, 1'b0,  0, 1'b1, -1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{4'd0,  5, 1'b0,  0, 1'b0, -1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{4'd6,  0, 1'b0,  0, 1'b1, -1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{4'd11, 1, 1'b1,  8, 1'b0, -1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{4'd9,  1, 1'b1,  8, 1'b0, -1, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{4'd10, 4, 1'b0, 20, 1'b0, -1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{4'd8,  0, 1'b1,  4, 1'b0, -1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{4'd4,  1, 1'b1,  8, 1'b0, -1, 1'b1, 1'b1, 1'b1};

    // reset state, checked while reset is still asserted
    #1 rst_n = 1'b0;
    #2 chk("reset_outs", {scl_o, sda_o, busy, rd_bit, rd_vld, err}, 6'b110000);
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    @(posedge clock); #1;
    chk("reset_rdy", {cmd_rdy, busy}, 2'b10);

    foreach (tbl[i]) begin
      exec(tbl[i].c, tbl[i].qd, tbl[i].sdi, blen, rdv, errs);
      chk("vec_len", blen, tbl[i].blen);
      chk("vec_err", errs, tbl[i].err);
      chk("vec_rdv_edge", rdv, tbl[i].rdv);
      chk("vec_rd_bit", rd_bit, tbl[i].rdb);
      chk("vec_bus", {scl_o, sda_o}, {tbl[i].fscl, tbl[i].fsda});
    end

    // reset in the middle of a STOP (qdiv=3): Q1 has scl=1, sda=0
    wait_rdy();
    cmd = 4'd4; qdiv = 8'd3; cmd_vld = 1'b1;
    @(posedge clock); #1;
    cmd_vld = 1'b0;
    repeat (5) @(posedge clock);
    #1 chk("pre_reset_bus", {scl_o, sda_o, busy}, 3'b101);
    #1 rst_n = 1'b0;
    #1 chk("mid_reset", {scl_o, sda_o, busy, rd_bit, rd_vld, err}, 6'b110000);
    @(posedge clock); #1;
    rst_n = 1'b1;
    m_scl = 1'b1; m_sda = 1'b1; m_rd_bit = 1'b0;
    @(posedge clock); #1;
    chk("post_reset", {cmd_rdy, busy, scl_o, sda_o, rd_vld, err}, 6'b101100);

    // clock stretch: bit 1, qdiv=1, scl_i low for 10 cycles starting in Q1
    wait_rdy();
    cmd = 4'd2; qdiv = 8'd1; sda_i = 1'b1; cmd_vld = 1'b1;
    @(posedge clock); #1;
    cmd_vld = 1'b0;
    e = 0; blen = 0;
    while (busy && e < 100) begin
      blen++;
      if (e == 2)  scl_i = 1'b0;
      if (e == 12) scl_i = 1'b1;
      @(posedge clock); #1;
      e++;
    end
    scl_i = 1'b1;
`ifdef I2C_CLK_STRETCH_EN
    chk("stretch_len", blen, 18);
`else
    chk("stretch_len", blen, 8);
`endif
    m_scl = 1'b0; m_sda = 1'b1;
    chk("stretch_bus", {scl_o, sda_o}, 2'b01);

    // random commands against the reference model
    for (int k = 0; k < 40; k++) begin
      rc  = 4'($urandom_range(0, 15));
      rqd = $urandom_range(0, 3);
      rsd = 1'($urandom_range(0, 1));
      exec(rc, rqd, rsd, blen, rdv, errs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
